// File: rtl/scalable_window_reducer.sv
// Per-core windowed signed accumulators reduced by a pipelined binary adder tree.
// Optional REDUCER_SATURATE_EN: saturating adds instead of wrapping adds.
module scalable_window_reducer #(
  parameter int unsigned CORE_COUNT   = 4,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned WINDOW_LEN   = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic [CORE_COUNT*SAMPLE_WIDTH-1:0] sample_data,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [RESULT_WIDTH-1:0]            result_data,
  output logic                               result_overflow
);

  localparam int unsigned LEVELS = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 0;
  localparam int unsigned LEAVES = 1 << LEVELS;
  localparam int unsigned CW     = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int unsigned RCW    = (LEVELS > 0) ? $clog2(LEVELS + 1) : 1;
  localparam int unsigned RW     = RESULT_WIDTH;

  typedef enum logic [1:0] {ACCUM, REDUCE, OUTPUT} stateT;

  stateT            state, stateNext;
  logic [CW-1:0]    beatCnt;
  logic [RCW-1:0]   redCnt;
  logic             winOvf;
  logic             beat, lastBeat, reduceDone, readyNext, validNext;
  logic [CORE_COUNT-1:0] accOvf;
  logic [LEVELS:0]  lvlOvf;
  logic [RW-1:0]    accSum [LEAVES];

  // Signed add returning {overflow, sum}; wraps or saturates depending on build.
  function automatic logic [RW:0] addOp(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW:0] wide;
    logic        ovf;
    wide = {a[RW-1], a} + {b[RW-1], b};
    ovf  = wide[RW] ^ wide[RW-1];
`ifdef REDUCER_SATURATE_EN
    if (ovf) wide[RW-1:0] = wide[RW] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
`endif
    return {ovf, wide[RW-1:0]};
  endfunction

  assign beat       = sample_valid && sample_ready;
  assign lastBeat   = beat && (beatCnt == CW'(WINDOW_LEN - 1));
  assign reduceDone = (state == REDUCE) && (redCnt == RCW'(LEVELS));

  // Per-core accumulators; padding leaves are constant zero.
  for (genvar i = 0; i < LEAVES; i++) begin : gCore
    if (i < CORE_COUNT) begin : gReal
      logic [RW-1:0] acc;
      logic [RW:0]   sumW;
      assign sumW      = addOp(acc, RW'(signed'(sample_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])));
      assign accOvf[i] = sumW[RW];
      assign accSum[i] = sumW[RW-1:0];
      always_ff @(posedge clk) begin
        if (reset)         acc <= '0;
        else if (lastBeat) acc <= '0;
        else if (beat)     acc <= sumW[RW-1:0];
      end
    end else begin : gPad
      assign accSum[i] = '0;
    end
  end

  // Adder tree: level 0 holds the window totals, level k is written once its inputs are valid.
  for (genvar k = 0; k <= LEVELS; k++) begin : gLvl
    localparam int unsigned N = LEAVES >> k;
    logic [RW-1:0] node [N];
    if (k == 0) begin : gLeaf
      assign lvlOvf[0] = 1'b0;
      always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
          if (reset)         node[j] <= '0;
          else if (lastBeat) node[j] <= accSum[j];
        end
      end
    end else begin : gAdd
      logic [N-1:0]  addOvf;
      logic [RW-1:0] addSum [N];
      logic          lvlHit;
      for (genvar j = 0; j < N; j++) begin : gNode
        logic [RW:0] w;
        assign w         = addOp(gLvl[k-1].node[2*j], gLvl[k-1].node[2*j+1]);
        assign addOvf[j] = w[RW];
        assign addSum[j] = w[RW-1:0];
      end
      assign lvlHit    = (state == REDUCE) && (redCnt == RCW'(k - 1));
      assign lvlOvf[k] = lvlHit && (|addOvf);
      always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
          if (reset)       node[j] <= '0;
          else if (lvlHit) node[j] <= addSum[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ACCUM:   if (lastBeat) stateNext = REDUCE;
      REDUCE:  if (reduceDone) stateNext = OUTPUT;
      OUTPUT:  if (result_ready) stateNext = ACCUM;
      default: stateNext = ACCUM;
    endcase
  end

  always_comb begin
    readyNext = 1'b0;
    validNext = 1'b0;
    readyNext = (stateNext == ACCUM);
    validNext = (stateNext == OUTPUT);
  end

  // Handshake flags track the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_ready <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      sample_ready <= readyNext;
      result_valid <= validNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beatCnt <= '0;
      redCnt  <= '0;
    end else begin
      if (beat) beatCnt <= lastBeat ? '0 : beatCnt + CW'(1);
      redCnt <= (state == REDUCE && !reduceDone) ? redCnt + RCW'(1) : '0;
    end
  end

  // Window overflow is sticky from the first accumulate until the result is taken.
  always_ff @(posedge clk) begin
    if (reset)                                winOvf <= 1'b0;
    else if (state == OUTPUT && result_ready) winOvf <= 1'b0;
    else if (beat && (|accOvf))               winOvf <= 1'b1;
    else if (state == REDUCE && (|lvlOvf))    winOvf <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_data     <= '0;
      result_overflow <= 1'b0;
    end else if (reduceDone) begin
      result_data     <= gLvl[LEVELS].node[0];
      result_overflow <= winOvf;
    end else if (state == OUTPUT && result_ready) begin
      result_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scalable_window_reducer.sv
// Directed bench for scalable_window_reducer: default, narrow-result and three-core instances.
module tb_scalable_window_reducer;

  logic        clk = 1'b0;
  logic        reset;
  int          tests = 0;
  int          fails = 0;

  logic        vA, rA, oVA, rrA, ovA;
  logic [63:0] dA;
  logic [31:0] odA;
  logic        vB, rB, oVB, rrB, ovB;
  logic [63:0] dB;
  logic [19:0] odB;
  logic        vC, rC, oVC, rrC, ovC;
  logic [47:0] dC;
  logic [31:0] odC;

  always #5 clk = ~clk;

  scalable_window_reducer dutA (
    .clk(clk), .reset(reset), .sample_valid(vA), .sample_ready(rA), .sample_data(dA),
    .result_valid(oVA), .result_ready(rrA), .result_data(odA), .result_overflow(ovA));

  scalable_window_reducer #(.RESULT_WIDTH(20)) dutB (
    .clk(clk), .reset(reset), .sample_valid(vB), .sample_ready(rB), .sample_data(dB),
    .result_valid(oVB), .result_ready(rrB), .result_data(odB), .result_overflow(ovB));

  scalable_window_reducer #(.CORE_COUNT(3)) dutC (
    .clk(clk), .reset(reset), .sample_valid(vC), .sample_ready(rC), .sample_data(dC),
    .result_valid(oVC), .result_ready(rrC), .result_data(odC), .result_overflow(ovC));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return rA;
      1:       return rB;
      default: return rC;
    endcase
  endfunction

  function automatic logic vld(input int d);
    case (d)
      0:       return oVA;
      1:       return oVB;
      default: return oVC;
    endcase
  endfunction

  // Drive one window of 8 accepted beats into instance d.
  task automatic feed(input int d, input logic [15:0] c0, input logic [15:0] c1,
                      input logic [15:0] c2, input logic [15:0] c3, input bit toggle,
                      output int cycles);
    int acc;
    logic v;
    acc = 0;
    cycles = 0;
    dA = {c3, c2, c1, c0};
    dB = {c3, c2, c1, c0};
    dC = {c2, c1, c0};
    while (acc < 8 && cycles < 64) begin
      v = toggle ? (cycles % 2 == 0) : 1'b1;
      case (d)
        0:       vA = v;
        1:       vB = v;
        default: vC = v;
      endcase
      if (v && rdy(d)) acc++;
      step();
      cycles++;
    end
    vA = 1'b0; vB = 1'b0; vC = 1'b0;
    tests++;
    if (acc != 8) begin
      fails++;
      $display("FAIL feed_dut%0d: accepted %0d beats, required 8", d, acc);
    end
  endtask

  task automatic waitRes(input int d, output int lat);
    lat = 0;
    while (!vld(d) && lat < 32) begin
      step();
      lat++;
    end
    tests++;
    if (vld(d) !== 1'b1) begin
      fails++;
      $display("FAIL wait_result_dut%0d: result_valid not seen within %0d cycles", d, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vA = 0; vB = 0; vC = 0; rrA = 0; rrB = 0; rrC = 0;
    dA = '0; dB = '0; dC = '0;
    step(); step();
    tests += 5;
    if (rA !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", rA); end
    if (oVA !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", oVA); end
    if (odA !== 32'd0) begin fails++; $display("FAIL reset_data: got %0h want 0", odA); end
    if (ovA !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovA); end
    if (rC !== 1'b0) begin fails++; $display("FAIL reset_ready_c3: got %b want 0", rC); end
    reset = 1'b0;
    step();
    tests++;
    if (rA !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", rA); end
  endtask

  task automatic test_basic_sum();
    int cy, lat;
    rrA = 1'b1;
    feed(0, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, cy);
    waitRes(0, lat);
    tests += 3;
    if (lat != 3) begin fails++; $display("FAIL basic_latency: got %0d want 3", lat); end
    if (odA !== 32'd32) begin fails++; $display("FAIL basic_data: got %0d want 32", $signed(odA)); end
    if (ovA !== 1'b0) begin fails++; $display("FAIL basic_ovf: got %b want 0", ovA); end
    step();
    tests += 2;
    if (oVA !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b want 0", oVA); end
    if (rA !== 1'b1) begin fails++; $display("FAIL basic_ready_back: got %b want 1", rA); end
  endtask

  task automatic test_idle_cycles();
    int cy, lat;
    feed(0, -16'sd1, 16'sd3, 16'sd3, 16'sd3, 1'b1, cy);
    tests++;
    if (cy != 15) begin fails++; $display("FAIL idle_cycles: window took %0d cycles want 15", cy); end
    waitRes(0, lat);
    tests += 2;
    if (odA !== 32'd64) begin fails++; $display("FAIL idle_data: got %0d want 64", $signed(odA)); end
    if (ovA !== 1'b0) begin fails++; $display("FAIL idle_ovf: got %b want 0", ovA); end
    step();
  endtask

  task automatic test_backpressure();
    int cy, lat, bad;
    logic [31:0] held;
    rrA = 1'b0;
    feed(0, 16'sd5, -16'sd3, 16'sd10, 16'sd0, 1'b0, cy);
    waitRes(0, lat);
    held = odA;
    tests++;
    if (held !== 32'd96) begin fails++; $display("FAIL bp_data: got %0d want 96", $signed(held)); end
    vA = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (oVA !== 1'b1 || odA !== 32'd96 || rA !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d cycles with valid=%b data=%0d ready=%b, want 1/96/0", bad, oVA, $signed(odA), rA);
    end
    rrA = 1'b1;
    step();
    vA = 1'b0;
    tests += 2;
    if (oVA !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", oVA); end
    if (rA !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", rA); end
  endtask

  task automatic test_back_to_back();
    int cy, lat;
    feed(0, 16'sd100, -16'sd200, 16'sd300, -16'sd50, 1'b0, cy);
    waitRes(0, lat);
    tests++;
    if (odA !== 32'd1200) begin fails++; $display("FAIL b2b_first: got %0d want 1200", $signed(odA)); end
    step();
    feed(0, -16'sd7, -16'sd7, -16'sd7, -16'sd7, 1'b0, cy);
    waitRes(0, lat);
    tests += 3;
    if (lat != 3) begin fails++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    if (odA !== -32'sd224) begin fails++; $display("FAIL b2b_second: got %0d want -224", $signed(odA)); end
    if (ovA !== 1'b0) begin fails++; $display("FAIL b2b_ovf: got %b want 0", ovA); end
    step();
  endtask

  task automatic test_overflow();
    int cy, lat;
    logic [19:0] expB;
`ifdef REDUCER_SATURATE_EN
    expB = 20'h7FFFF;
`else
    expB = 20'hFFFE0;
`endif
    rrB = 1'b1;
    feed(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, cy);
    waitRes(1, lat);
    tests += 3;
    if (odB !== expB) begin fails++; $display("FAIL ovf_data: got %0h want %0h", odB, expB); end
    if (ovB !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", ovB); end
    if (lat != 3) begin fails++; $display("FAIL ovf_latency: got %0d want 3", lat); end
    step();
    tests++;
    if (ovB !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", ovB); end
  endtask

  task automatic test_reset_mid_window();
    int cy, lat, stray;
    rrA = 1'b1;
    dA = {4{16'sd5}};
    vA = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vA = 1'b0;
    reset = 1'b1;
    step();
    tests += 2;
    if (rA !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %b want 0", rA); end
    if (oVA !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", oVA); end
    reset = 1'b0;
    step();
    feed(0, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 1'b0, cy);
    waitRes(0, lat);
    tests += 2;
    if (odA !== 32'd64) begin fails++; $display("FAIL midrst_data: got %0d want 64", $signed(odA)); end
    if (lat != 3) begin fails++; $display("FAIL midrst_latency: got %0d want 3", lat); end
    step();
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (oVA) stray++;
      step();
    end
    tests++;
    if (stray != 0) begin fails++; $display("FAIL midrst_stray: %0d extra valid cycles want 0", stray); end
  endtask

  task automatic test_three_cores();
    int cy, lat;
    rrC = 1'b1;
    feed(2, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0, cy);
    waitRes(2, lat);
    tests += 3;
    if (odC !== 32'd24) begin fails++; $display("FAIL c3_data: got %0d want 24", $signed(odC)); end
    if (lat != 3) begin fails++; $display("FAIL c3_latency: got %0d want 3", lat); end
    if (ovC !== 1'b0) begin fails++; $display("FAIL c3_ovf: got %b want 0", ovC); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_idle_cycles();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_window();
    test_three_cores();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
